// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : unified_mem_arbiter                                          |
// | Description : Round-robin arbiter sharing one single-ported memory between  |
// |               the instruction-fetch and load/store ports, with CPU stall.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifetch_req,
    input  logic [ADDR_WIDTH-1:0] ifetch_addr,
    output logic [DATA_WIDTH-1:0] ifetch_rdata,
    output logic                  ifetch_valid,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_valid,
    output logic                  stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_wait    = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;
    localparam logic [1:0] c_cnt_init   = 2'(MEM_LATENCY - 1);
    localparam logic       c_port_fetch = 1'b0;
    localparam logic       c_port_data  = 1'b1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            w_cnt_nxt;
    logic                  r_last_grant;
    logic                  w_last_grant_nxt;
    logic                  r_grant;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] r_ifetch_rdata;
    logic [DATA_WIDTH-1:0] r_data_rdata;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_grant          = r_grant;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (r_state)
            c_st_idle: begin
                if (ifetch_req || data_req) begin
                    // On a tie the port that did not win last time gets the memory
                    if (data_req && (!ifetch_req || (r_last_grant == c_port_fetch))) begin
                        w_grant     = c_port_data;
                        mem_we      = data_we;
                        mem_addr    = data_addr;
                        mem_wdata   = data_we ? data_wdata : '0;
                        w_state_nxt = data_we ? c_st_done : c_st_wait;
                    end else begin
                        w_grant     = c_port_fetch;
                        mem_addr    = ifetch_addr;
                        w_state_nxt = c_st_wait;
                    end
                    mem_en           = 1'b1;
                    w_last_grant_nxt = w_grant;
                    w_cnt_nxt        = c_cnt_init;
                end
            end
            c_st_wait: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        // Nothing reaches the memory while the block is held in reset
        if (reset) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_cnt          <= 2'd0;
            r_last_grant   <= c_port_data;
            r_grant        <= c_port_fetch;
            r_ifetch_rdata <= '0;
            r_data_rdata   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant;
            if ((r_state == c_st_wait) && (r_cnt == 2'd0)) begin
                if (r_grant == c_port_data) begin
                    r_data_rdata <= mem_rdata;
                end else begin
                    r_ifetch_rdata <= mem_rdata;
                end
            end
        end
    end

    assign ifetch_rdata = r_ifetch_rdata;
    assign data_rdata   = r_data_rdata;
    assign ifetch_valid = (r_state == c_st_done) && (r_grant == c_port_fetch);
    assign data_valid   = (r_state == c_st_done) && (r_grant == c_port_data);
    assign stall        = (ifetch_req && !ifetch_valid) || (data_req && !data_valid);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_unified_mem_arbiter                                       |
// | Description : Scoreboard bench for unified_mem_arbiter at latencies 1,2,4. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_unified_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
    } cpl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'h9E3779B9 * 32'(i)) ^ 32'h13579BDF;
    endfunction

    task automatic check(input string name, input int lat, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (lat=%0d cyc=%0d): got %h, expected %h", name, lat, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_lat
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

        logic          reset, ifetch_req, data_req, data_we;
        logic [AW-1:0] ifetch_addr, data_addr, mem_addr;
        logic [DW-1:0] data_wdata, ifetch_rdata, data_rdata, mem_wdata, mem_rdata;
        logic          ifetch_valid, data_valid, stall, mem_en, mem_we;

        unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) u_dut (
            .clk(clk), .reset(reset),
            .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
            .ifetch_rdata(ifetch_rdata), .ifetch_valid(ifetch_valid),
            .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
            .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
            .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        // Memory macro: read data appears L cycles after the strobe, junk otherwise
        logic [DW-1:0] mem [64];
        logic [DW-1:0] pipe [4];
        assign mem_rdata = pipe[L-1];

        initial begin : env_mem
            for (int i = 0; i < 64; i++) mem[i] = init_word(i);
            for (int i = 0; i < 4; i++) pipe[i] = '0;
            forever begin
                @(posedge clk);
                if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
                for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
                pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : DW'($urandom);
            end
        end

        // Reference model: transaction-level timeline of the shared memory
        iss_t          q_iss[$];
        cpl_t          q_fv[$];
        cpl_t          q_dv[$];
        logic [DW-1:0] ref_mem [64];
        logic          rst_s;
        logic          rst_d = 1'b1;

        initial begin : model
            int            free_at;
            logic          last_data;
            logic          pick_data;
            logic [DW-1:0] last_frd, last_drd;
            iss_t          ie;
            cpl_t          ce;
            free_at   = 0;
            last_data = 1'b1;
            last_frd  = '0;
            last_drd  = '0;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            forever begin
                @(negedge clk);
                rst_s = rst_d;
                rst_d = reset;
                if (reset) begin
                    while (q_fv.size() > 0 && q_fv[$].cyc > cyc) void'(q_fv.pop_back());
                    while (q_dv.size() > 0 && q_dv[$].cyc > cyc) void'(q_dv.pop_back());
                    q_iss.delete();
                    free_at   = cyc + 1;
                    last_data = 1'b1;
                    last_frd  = '0;
                    last_drd  = '0;
                end else if (cyc >= free_at && (ifetch_req || data_req)) begin
                    pick_data = data_req && (!ifetch_req || !last_data);
                    last_data = pick_data;
                    ie.cyc    = cyc;
                    ie.we     = pick_data && data_we;
                    ie.addr   = pick_data ? data_addr : ifetch_addr;
                    ie.wdata  = ie.we ? data_wdata : '0;
                    q_iss.push_back(ie);
                    if (ie.we) begin
                        ref_mem[ie.addr] = ie.wdata;
                        ce.cyc   = cyc + 1;
                        ce.rdata = last_drd;
                        q_dv.push_back(ce);
                        free_at  = cyc + 2;
                    end else begin
                        ce.cyc  = cyc + L + 1;
                        free_at = cyc + L + 2;
                        if (pick_data) begin
                            last_drd = ref_mem[ie.addr];
                            ce.rdata = last_drd;
                            q_dv.push_back(ce);
                        end else begin
                            last_frd = ref_mem[ie.addr];
                            ce.rdata = last_frd;
                            q_fv.push_back(ce);
                        end
                    end
                end
            end
        end

        initial begin : monitor
            logic exp_fv, exp_dv, exp_iss;
            iss_t ie;
            cpl_t ce;
            forever begin
                @(negedge clk);
                #1;
                exp_fv  = (q_fv.size() > 0) && (q_fv[0].cyc == cyc);
                exp_dv  = (q_dv.size() > 0) && (q_dv[0].cyc == cyc);
                exp_iss = (q_iss.size() > 0) && (q_iss[0].cyc == cyc);
                check("ifetch_valid", L, 64'(ifetch_valid), 64'(exp_fv));
                check("data_valid", L, 64'(data_valid), 64'(exp_dv));
                check("valid_exclusive", L, 64'(ifetch_valid && data_valid), 64'd0);
                check("stall", L, 64'(stall), 64'((ifetch_req && !exp_fv) || (data_req && !exp_dv)));
                check("mem_en", L, 64'(mem_en), 64'(exp_iss));
                if (exp_fv) begin
                    ce = q_fv.pop_front();
                    check("ifetch_rdata", L, 64'(ifetch_rdata), 64'(ce.rdata));
                end
                if (exp_dv) begin
                    ce = q_dv.pop_front();
                    check("data_rdata", L, 64'(data_rdata), 64'(ce.rdata));
                end
                if (exp_iss) begin
                    ie = q_iss.pop_front();
                    check("mem_we", L, 64'(mem_we), 64'(ie.we));
                    check("mem_addr", L, 64'(mem_addr), 64'(ie.addr));
                    check("mem_wdata", L, 64'(mem_wdata), 64'(ie.wdata));
                end
                if (rst_s) check("rst_rdata", L, {ifetch_rdata, data_rdata}, 64'd0);
                if (reset) check("rst_mem_bus", L, 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
            end
        end

        task automatic run_fetch(input int n, input int max_gap, input int amask, input int abase);
            logic got;
            for (int k = 0; k < n; k++) begin
                int gap = $urandom_range(max_gap, 0);
                if (gap > 0) ifetch_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
                ifetch_req  = 1'b1;
                ifetch_addr = AW'(abase | (int'($urandom) & amask));
                got = 1'b0;
                for (int t = 0; t < 60 && !got; t++) begin
                    @(negedge clk);
                    got = ifetch_valid;
                end
                check("ifetch_handshake", L, 64'(got), 64'd1);
                @(posedge clk); #1;
            end
            ifetch_req = 1'b0;
        endtask

        // we_mode: 0 load, 1 store, 2 random
        task automatic run_data(input int n, input int max_gap, input int amask, input int abase,
                                input int we_mode, input logic [DW-1:0] wd);
            logic got;
            for (int k = 0; k < n; k++) begin
                int gap = $urandom_range(max_gap, 0);
                if (gap > 0) data_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
                data_req   = 1'b1;
                data_addr  = AW'(abase | (int'($urandom) & amask));
                data_we    = (we_mode == 2) ? 1'($urandom) : (we_mode == 1);
                data_wdata = (we_mode == 2) ? DW'($urandom) : wd;
                got = 1'b0;
                for (int t = 0; t < 60 && !got; t++) begin
                    @(negedge clk);
                    got = data_valid;
                end
                check("data_handshake", L, 64'(got), 64'd1);
                @(posedge clk); #1;
            end
            data_req = 1'b0;
        endtask

        task automatic do_reset(input int n);
            reset = 1'b1;
            for (int k = 0; k < n; k++) begin
                ifetch_req  = 1'($urandom);
                data_req    = 1'($urandom);
                data_we     = 1'($urandom);
                ifetch_addr = AW'($urandom);
                data_addr   = AW'($urandom);
                data_wdata  = DW'($urandom);
                @(posedge clk); #1;
            end
            reset      = 1'b0;
            ifetch_req = 1'b0;
            data_req   = 1'b0;
        endtask

        initial begin : stim
            logic got;
            reset = 1'b1; ifetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
            ifetch_addr = '0; data_addr = '0; data_wdata = '0;
            do_reset(3);
            repeat (2) begin @(posedge clk); #1; end
            run_fetch(1, 0, 0, 6'h01);
            run_fetch(1, 0, 0, 6'h04);
            run_data(1, 0, 0, 6'h10, 1, 32'hDEADBEEF);
            do_reset(2);
            fork
                run_fetch(1, 0, 0, 6'h08);
                run_data(1, 0, 0, 6'h10, 0, '0);
            join
            // Both ports continuously busy, disjoint address halves
            fork
                run_fetch(10, 0, 31, 0);
                run_data(10, 0, 31, 32, 2, '0);
            join
            fork
                run_fetch(25, 3, 63, 0);
                run_data(25, 3, 63, 0, 2, '0);
            join
            // Reset arriving while a fetch is waiting on memory
            ifetch_req  = 1'b1;
            ifetch_addr = 6'h22;
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                got = mem_en;
            end
            check("abort_issue", L, 64'(got), 64'd1);
            @(posedge clk); #1;
            do_reset(3);
            run_fetch(1, 0, 0, 6'h01);
            repeat (3) begin @(posedge clk); #1; end
            done_cnt++;
        end
    end

    initial begin : finisher
        for (int i = 0; i < 30000 && done_cnt != 3; i++) @(posedge clk);
        if (done_cnt != 3) begin
            miscompares++;
            $display("FAIL global_timeout: got %0d instances done, expected 3", done_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the single-cycle datapath, turning it into a stalling design. Each access runs through a request/valid handshake, and round-robin arbitration resolves collisions. A stall output freezes the PC and register-file writes while any access is outstanding. The block sits between the CPU top level and the unified memory macro.

Parameters:
ADDR_WIDTH, 6, word address width, matching the 6-bit imem/dmem address buses
DATA_WIDTH, 32, data word width
MEM_LATENCY, 1, memory read latency in cycles from the mem_en cycle to a valid mem_rdata; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ifetch_req  in  1  fetch request; level, held until ifetch_valid
ifetch_addr  in  ADDR_WIDTH  fetch word address
ifetch_rdata  out  DATA_WIDTH  fetched instruction, registered
ifetch_valid  out  1  one-cycle completion pulse for fetch
data_req  in  1  data request; level, held until data_valid
data_we  in  1  1 = store, 0 = load
data_addr  in  ADDR_WIDTH  data word address
data_wdata  in  DATA_WIDTH  store data
data_rdata  out  DATA_WIDTH  load data, registered
data_valid  out  1  one-cycle completion pulse for data
stall  out  1  CPU hold: (ifetch_req & ~ifetch_valid) | (data_req & ~data_valid), combinational
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Reset: state=IDLE, wait counter=0, last_grant=DATA (so fetch wins the first tie). ifetch_valid=data_valid=0, ifetch_rdata=data_rdata=0. mem_en=mem_we=0, mem_addr=mem_wdata=0. Reset takes priority over everything, including mid-access: no valid pulse is produced for an aborted access.
- States:
  - IDLE: arbitrate this cycle.
  - WAIT: counting read latency.
  - DONE: one cycle; completion pulse asserted.
- IDLE with no request: mem_* outputs are 0; remain in IDLE.
- IDLE arbitration:
  - One requester: it is granted.
  - Both requesting: grant the port not equal to last_grant.
  - On grant, update last_grant.
- Issue (same IDLE cycle T, combinational): mem_en=1. mem_addr/mem_we/mem_wdata come from the granted port; mem_we=0 and mem_wdata=0 for a fetch.
- Read (fetch, or load with data_we=0): go to WAIT with counter=MEM_LATENCY-1.
  - On the cycle where counter==0 (cycle T+MEM_LATENCY), capture mem_rdata into the granted port's rdata register and go to DONE.
  - Valid is high in cycle T+MEM_LATENCY+1.
- Write (data_we=1): go directly to DONE. data_valid is high in T+1 and data_rdata is unchanged.
- DONE: the granted port's valid=1 for exactly one cycle; requests are ignored; next state is IDLE.
  - Requesters sample valid and may drop or replace req at the following edge.
  - A request still high in the IDLE after DONE is treated as a new access.
- Throughput: a read occupies MEM_LATENCY+2 cycles; a write occupies 2 cycles. There is no overlap between accesses.
- rdata registers hold their value until the next completed read on the same port.
- Requester drops req mid-access: the access still completes and the valid pulse still fires. Inputs are sampled only in the IDLE issue cycle.
- Starvation: with both ports held high continuously, grants strictly alternate.
- Only one of ifetch_valid and data_valid is ever high in a given cycle.

Test Plan:
- Reset behaviour, MEM_LATENCY=2: assert reset 3 cycles with random inputs, including mid-WAIT -> all outputs 0 and no valid pulse. Then a fetch at addr 0x01 completes normally.
- Single fetch, MEM_LATENCY=2: ifetch_req=1, addr 0x04 at T; memory returns 0x00500093 at T+2.
  - Expect mem_en=1, mem_addr=0x04 at T.
  - Expect ifetch_valid=1 and ifetch_rdata=0x00500093 at T+3.
  - Expect stall=1 for T..T+2 and 0 at T+3.
- Store: data_req=1, data_we=1, addr 0x10, wdata 0xDEADBEEF at T -> mem_en=mem_we=1, mem_wdata=0xDEADBEEF at T; data_valid=1 at T+1; data_rdata unchanged.
- Collision after reset: both requests rise at T, load from 0x10 -> fetch issued at T. Load issued at T+4 (MEM_LATENCY=2) and returns the stored 0xDEADBEEF; data_valid at T+7.
- Fairness: both requests held 20 cycles, MEM_LATENCY=1 -> mem_en grants alternate F,D,F,D…; no two consecutive grants to the same port; valid pulses never overlap.
- Latency sweep: MEM_LATENCY=1 and 4, with 50 random fetch/load/store mixes against a memory model -> every returned rdata matches the model, and each valid arrives exactly MEM_LATENCY+1 cycles after its mem_en.
